// File: rtl/xm23_fetch_pkg.sv
// Shared types and constants for the XM23 stage-1 instruction fetch block.
package xm23_fetch_pkg;

  typedef enum logic [2:0] {
    StStart,
    StReq,
    StHold,
    StNext,
    StDrain,
    StFault
  } fetch_state_e;

  localparam logic [15:0] ResetVector = 16'h0000;

  // Width of the request watchdog counter; bounds TIMEOUT_CYCLES to 1..255.
  localparam int unsigned WdogWidth = 8;

endpackage

// File: rtl/xm23_fetch_watchdog.sv
// Unacknowledged-request watchdog for the XM23 fetch stage.
// expired is combinational so the fault lands on the edge that ends the
// limit-th unacknowledged cycle.
module xm23_fetch_watchdog
  import xm23_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 count_en,
  input  logic                 clear,
  input  logic [WdogWidth-1:0] limit,
  output logic                 expired
);

  logic [WdogWidth-1:0] count_q;
  logic [WdogWidth:0]   count_next;

  assign count_next = {1'b0, count_q} + {{WdogWidth{1'b0}}, 1'b1};
  assign expired    = count_en && (count_next == {1'b0, limit});

  // Count unacknowledged request cycles; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (count_en) begin
      count_q <= count_next[WdogWidth-1:0];
    end
  end

endmodule

// File: rtl/xm23_fetch_stage.sv
// XM23 stage-1 instruction fetch: fetch PC, req/ack handshake with instruction
// memory, instruction register for decode, mispredict redirect handling.
// Optional request timeout enabled by defining XM23_FETCH_TIMEOUT_EN.
module xm23_fetch_stage
  import xm23_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC       = ResetVector,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  stall,
  input  logic [15:0] pc_next_in,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir,
  output logic        ir_valid,
  output logic [15:0] pc_out,
  output logic [2:0]  three_msb,
  output logic [12:0] thirteen_lsb,
  output logic        fetch_fault
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > (2 ** WdogWidth) - 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  fetch_state_e state_q, state_d;
  logic [15:0]  fetch_pc_q, fetch_pc_d;
  logic [15:0]  addr_q, addr_d;
  logic [15:0]  buf_q, buf_d;
  logic [15:0]  ir_q, ir_d;
  logic [15:0]  pc_out_q, pc_out_d;
  logic         ir_valid_q, ir_valid_d;
  logic         fault_q, fault_d;
  logic         stalled;
  logic         wd_expired;

  assign stalled = |stall;

`ifdef XM23_FETCH_TIMEOUT_EN
  logic wd_count_en;

  assign wd_count_en = ((state_q == StReq) || (state_q == StDrain)) && !imem_ack;

  xm23_fetch_watchdog u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .count_en (wd_count_en),
    .clear    (!wd_count_en),
    .limit    (WdogWidth'(TIMEOUT_CYCLES)),
    .expired  (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state logic: timeout, then redirect, then the normal fetch sequence.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    buf_d      = buf_q;
    ir_d       = ir_q;
    pc_out_d   = pc_out_q;
    ir_valid_d = 1'b0;
    fault_d    = fault_q;

    if (wd_expired && (state_q != StFault)) begin
      fault_d = 1'b1;
      state_d = StFault;
    end else if (redirect && (state_q != StFault)) begin
      // Any buffered word is simply abandoned; buf is rewritten before reuse.
      fetch_pc_d = redirect_pc;
      unique case (state_q)
        StReq: begin
          if (imem_ack) begin
            addr_d  = redirect_pc;
            state_d = StReq;
          end else begin
            // Keep the outstanding request intact until memory completes it.
            state_d = StDrain;
          end
        end
        StDrain: begin
          // An ack here closes the old transfer, so the restart can go out now.
          if (imem_ack) begin
            addr_d  = redirect_pc;
            state_d = StReq;
          end
        end
        default: begin
          addr_d  = redirect_pc;
          state_d = StReq;
        end
      endcase
    end else begin
      unique case (state_q)
        StStart: begin
          addr_d  = fetch_pc_q;
          state_d = StReq;
        end
        StReq: begin
          if (imem_ack) begin
            if (stalled) begin
              buf_d   = imem_rdata;
              state_d = StHold;
            end else begin
              ir_d       = imem_rdata;
              pc_out_d   = addr_q;
              ir_valid_d = 1'b1;
              state_d    = StNext;
            end
          end
        end
        StHold: begin
          if (!stalled) begin
            ir_d       = buf_q;
            pc_out_d   = addr_q;
            ir_valid_d = 1'b1;
            state_d    = StNext;
          end
        end
        StNext: begin
          fetch_pc_d = pc_next_in;
          addr_d     = pc_next_in;
          state_d    = StReq;
        end
        StDrain: begin
          if (imem_ack) begin
            addr_d  = fetch_pc_q;
            state_d = StReq;
          end
        end
        StFault: ;
        default: state_d = StStart;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StStart;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      buf_q      <= 16'h0000;
      ir_q       <= 16'h0000;
      pc_out_q   <= RESET_PC;
      ir_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      ir_q       <= ir_d;
      pc_out_q   <= pc_out_d;
      ir_valid_q <= ir_valid_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_req     = (state_q == StReq) || (state_q == StDrain);
  assign imem_addr    = addr_q;
  assign ir           = ir_q;
  assign ir_valid     = ir_valid_q;
  assign pc_out       = pc_out_q;
  assign three_msb    = ir_q[15:13];
  assign thirteen_lsb = ir_q[12:0];
  assign fetch_fault  = fault_q;

endmodule

// File: doc/xm23_fetch_stage.md
# xm23_fetch_stage

Stage-1 instruction fetch for the XM23 pipeline. Holds the fetch PC and runs a req/ack handshake with instruction memory. Latches the returned word into the instruction register that feeds decode, and exposes the opcode/offset fields and instruction PC to the pipeline controller. Takes the predicted next PC and the stall vector back from the controller, and takes a mispredict redirect from execute.

## Interface
Parameters:
- RESET_PC, 16'h0000, fetch address after reset.
- TIMEOUT_CYCLES, 255, range 1..255; cycles of unacknowledged request before fault. Used only with the timeout feature.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  8  controller stall vector; any bit set = decode cannot accept.
- pc_next_in  in  16  predicted next PC from controller, derived from pc_out/ir.
- redirect  in  1  execute mispredict strobe.
- redirect_pc  in  16  restart address (LBPC), sampled when redirect=1.
- imem_req  out  1  memory request.
- imem_addr  out  16  request address; stable while imem_req=1.
- imem_ack  in  1  data valid / request complete.
- imem_rdata  in  16  instruction word, valid with imem_ack.
- ir  out  16  instruction register to decode.
- ir_valid  out  1  one-cycle strobe: ir holds a new instruction.
- pc_out  out  16  address of the instruction in ir (controller PC_in).
- three_msb  out  3  ir[15:13], combinational.
- thirteen_lsb  out  13  ir[12:0], combinational.
- fetch_fault  out  1  sticky timeout fault.

## Operation
- State machine states:
  - START: after reset; imem_req=0.
  - REQ: imem_req=1.
  - HOLD: word buffered, decode stalled.
  - NEXT: pick up pc_next_in.
  - DRAIN: discard an in-flight response.
  - FAULT: timeout.
- Transitions:
  - START -> REQ, with addr_q = fetch_pc.
  - REQ & ack & stall==0: ir<=rdata, pc_out<=addr_q, ir_valid<=1; go to NEXT.
  - REQ & ack & stall!=0: buf<=rdata; go to HOLD. ir unchanged.
  - HOLD & stall==0: ir<=buf, pc_out<=addr_q, ir_valid<=1; go to NEXT.
  - NEXT: fetch_pc<=pc_next_in, addr_q<=pc_next_in; go to REQ.
- ir_valid is 0 in every cycle not listed above.
- Redirect has highest priority, in any state except FAULT:
  - fetch_pc<=redirect_pc; ir_valid<=0; buf is discarded.
  - In REQ without ack: go to DRAIN. imem_req and imem_addr stay unchanged until ack.
  - In REQ with ack, HOLD, NEXT or START: addr_q<=redirect_pc; go to REQ. Returned data is dropped.
  - In DRAIN: update fetch_pc only; stay in DRAIN.
- DRAIN & ack: discard data; addr_q<=fetch_pc; go to REQ.
- ir and pc_out keep their last value in all non-load cycles.
- Arithmetic: the block does no PC arithmetic. pc_next_in is used verbatim. Addresses wrap naturally at 16 bits.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, ir=16'h0000, ir_valid=0, pc_out=RESET_PC, fetch_fault=0, state=START.
- Reset mid-transaction abandons the outstanding request. Instruction memory is reset by the same rst.
- Best case with ack in the first REQ cycle: one instruction every 2 cycles (REQ, NEXT).
- In NEXT, pc_next_in is sampled one posedge after ir loads. The controller's negedge update falls in between.
- Handshake: imem_req is held with a constant address until the cycle imem_ack=1. imem_ack outside REQ/DRAIN is ignored.
- Redirect and ack in the same cycle: redirect wins and the word is dropped.
- Redirect-to-first-fetch latency: request issued the next cycle, or after ack completes DRAIN.

## Configuration
- XM23_FETCH_TIMEOUT_EN:
  - Defined: an 8-bit counter increments each REQ/DRAIN cycle with ack=0 and clears on ack or on leaving those states. When it reaches TIMEOUT_CYCLES: fetch_fault<=1 and go to FAULT. FAULT holds imem_req=0 and ir_valid=0, ignores redirect, and is left only by rst.
  - Undefined: no counter and no FAULT state; fetch_fault is tied 0.

## Structure
- Package xm23_fetch_pkg holds:
  - the state enum;
  - the 16'h0000 reset-vector default;
  - the timeout counter width.
- The timeout counter is sub-module xm23_fetch_watchdog, with ports clk, rst, count_en, clear, limit, expired. It is instantiated only under XM23_FETCH_TIMEOUT_EN.

## Test plan
- Single-cycle ack, words 16'h1234 @0x0000 and 16'h5678 @ pc_next_in=0x0002:
  - ir_valid pulses on posedge 2 and 4;
  - pc_out goes 0x0000 then 0x0002;
  - three_msb=3'b000 for the first word.
- stall=8'h04 at the cycle of ack, held 3 cycles:
  - state is HOLD;
  - ir unchanged;
  - ir loads the buffered word the cycle after stall clears;
  - imem_req=0 throughout.
- Ack delayed 5 cycles, redirect to 0x0040 in cycle 2:
  - req/addr stay stable until ack;
  - the returned word is dropped with no ir_valid;
  - the next request is at 0x0040.
- Redirect to 0x0100 coincident with ack: the word is dropped and the next imem_addr is 0x0100.
- rst asserted while in HOLD: all outputs return to reset values next cycle and the first request is at RESET_PC.
- With the macro, TIMEOUT_CYCLES=4 and no ack:
  - fetch_fault=1 after 4 request cycles;
  - imem_req drops;
  - fetch_fault stays set until rst.
